fnd_scan_controller: RTL

FND_SCAN_CONTROLLER -- requirements
Module: fnd_scan_controller

---
 rtl/fnd_pkg.sv | 28 ++
 rtl/fnd_scan_controller_bcd_to_seg.sv | 29 ++
 rtl/fnd_scan_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared constants for the seven-segment scan display.
// Active-low segment patterns and digit enables.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] DIGIT_OFF = 4'b1111;

    typedef enum logic {
        ST_LOAD,
        ST_SCAN
    } scan_state_t;

    function automatic logic [3:0] digit_enable(input logic [1:0] idx);
        return DIGIT_OFF ^ (4'b0001 << idx);
    endfunction

endpackage

// File: rtl/fnd_scan_controller_bcd_to_seg.sv
// Combinational digit decoder: 4-bit digit plus dash flag to segments g..a.
// Codes above 9 fall back to a dash.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH[6:0];
        case (digit)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_DASH[6:0];
        endcase
        if (dash) seg = SEG_DASH[6:0];
    end

endmodule

// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed display scanner with frame-synchronous snapshot.
// Optional FND_DP_BLINK_EN: separator dp blinks with the low field.
module fnd_scan_controller
    import fnd_pkg::*;
#(
    parameter int unsigned LOW_MAX  = 100,
    parameter int unsigned HIGH_MAX = 60,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(LOW_MAX)-1:0]  bcd_low,
    input  logic [$clog2(HIGH_MAX)-1:0] bcd_high,
    output logic [7:0]                  seg,
    output logic [3:0]                  seg_comm
);

    localparam int unsigned LW = $clog2(LOW_MAX);
    localparam int unsigned HW = $clog2(HIGH_MAX);
    localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic [CW-1:0] pre_cnt;
    logic [1:0]    idx;
    logic [LW-1:0] snap_low;
    logic [HW-1:0] snap_high;
    logic          tick;
    logic          wrap;
    logic          load;
    logic          lo_dash;
    logic          hi_dash;
    logic [3:0]    digit;
    logic          dash;
    logic          dp_on;
    logic [6:0]    seg7;
    logic [7:0]    seg_nxt;
    logic [3:0]    comm_nxt;

    assign tick    = (32'(pre_cnt) == SCAN_DIV - 1);
    assign lo_dash = (32'(snap_low) >= LOW_MAX);
    assign hi_dash = (32'(snap_high) >= HIGH_MAX);

    always_comb begin
        digit = 4'd0;
        dash  = 1'b0;
        unique case (idx)
            2'd0: begin
                digit = 4'(32'(snap_low) % 10);
                dash  = lo_dash;
            end
            2'd1: begin
                digit = 4'(32'(snap_low) / 10);
                dash  = lo_dash;
            end
            2'd2: begin
                digit = 4'(32'(snap_high) % 10);
                dash  = hi_dash;
            end
            2'd3: begin
                digit = 4'(32'(snap_high) / 10);
                dash  = hi_dash;
            end
        endcase
    end

    bcd_to_seg u_dec (
        .digit (digit),
        .dash  (dash),
        .seg   (seg7)
    );

`ifdef FND_DP_BLINK_EN
    assign dp_on = (idx == 2'd2) && (32'(snap_low) < LOW_MAX / 2);
`else
    assign dp_on = (idx == 2'd2);
`endif

    // Scan ticks blank the outputs for one cycle to avoid ghosting.
    always_comb begin
        state_nxt = ST_SCAN;
        wrap      = tick && (idx == 2'd3);
        load      = 1'b0;
        seg_nxt   = SEG_BLANK;
        comm_nxt  = DIGIT_OFF;
        unique case (state)
            ST_LOAD: begin
                load = 1'b1;
            end
            ST_SCAN: begin
                load = wrap;
                if (!tick) begin
                    seg_nxt  = {~dp_on, seg7};
                    comm_nxt = digit_enable(idx);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_LOAD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt   <= '0;
            idx       <= '0;
            snap_low  <= '0;
            snap_high <= '0;
            seg       <= SEG_BLANK;
            seg_comm  <= DIGIT_OFF;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) idx <= idx + 2'd1;
            if (load) begin
                snap_low  <= bcd_low;
                snap_high <= bcd_high;
            end
            seg      <= seg_nxt;
            seg_comm <= comm_nxt;
        end
    end

endmodule
